agc_gain_sequencer: RTL and testbench

Gain-switch sequencer between the automatic gain control decision logic and the analog PGA/relay gain select. It accepts gain-change requests through a valid/ready handshake and applies them to `gain_ctrl` one level at a time, with a settling time after each level change. It blanks ADC samples while the analog path settles and enforces a minimum dwell time before the next request is accepted. A manual override path has priority over requests.

---
 rtl/agc_gain_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_agc_gain_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_sequencer.sv
// agc_gain_sequencer
//
// Sits between the AGC decision logic and the analog PGA/relay gain select.
// Gain-change requests arrive on a valid/ready handshake. Each request is
// applied to gain_ctrl one code at a time. After every one-code step the
// block waits SETTLE_CYCLES while the analog path settles. Once the target is
// reached it waits DWELL_CYCLES before it accepts the next request. ADC
// samples taken while the path is settling are blanked. A level-sensitive
// manual override has priority over the request port.
//
// Ports:
//   clk        single rising-edge clock
//   rst        asynchronous reset, active high
//   req_valid  gain change request strobe
//   req_gain   requested gain code (clamped to MAX_GAIN)
//   req_ready  high when a request would be accepted this cycle
//   man_en     manual override enable (level sensitive)
//   man_gain   manual gain code (clamped to MAX_GAIN)
//   adc_data   raw ADC sample
//   adc_valid  ADC sample strobe
//   out_data   registered ADC sample
//   out_valid  registered sample strobe, forced low while settling
//   out_gain   gain code in effect when the sample was taken
//   gain_ctrl  registered gain select to the PGA
//   settling   high while stepping or settling
//   busy       high whenever a gain sequence is in progress
module agc_gain_sequencer #(
  parameter int         SETTLE_CYCLES = 64,
  parameter int         DWELL_CYCLES  = 1024,
  parameter logic [1:0] GAIN_INIT     = 2'd0,
  parameter logic [1:0] MAX_GAIN      = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_gain,
  output logic        req_ready,
  input  logic        man_en,
  input  logic [1:0]  man_gain,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  output logic [11:0] out_data,
  output logic        out_valid,
  output logic [1:0]  out_gain,
  output logic [1:0]  gain_ctrl,
  output logic        settling,
  output logic        busy
);

  // One counter is shared by SETTLE and DWELL, so it is sized for the longer
  // of the two intervals. It only ever holds (interval - 1) down to 0.
  localparam int MAX_CYC = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LOAD  = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DWELL  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  gain_q, gain_d;
  logic [1:0]  target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_gain_q, out_gain_d;

  logic [1:0]  req_gain_c;
  logic [1:0]  man_gain_c;
  logic        man_hit;
  logic        req_fire;

  function automatic logic [1:0] clamp_gain(input logic [1:0] g);
    return (g > MAX_GAIN) ? MAX_GAIN : g;
  endfunction

  // State register plus every other flop in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gain_q      <= GAIN_INIT;
      target_q    <= GAIN_INIT;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_gain_q  <= GAIN_INIT;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_gain_q  <= out_gain_d;
    end
  end

  // Next-state logic. The override only counts as a hit when it actually
  // changes the goal, so holding man_en at the current target is harmless.
  // In SETTLE the exit decision looks at target_d so that a retarget landing
  // on the final settle cycle is still honoured.
  always_comb begin
    req_gain_c = clamp_gain(req_gain);
    man_gain_c = clamp_gain(man_gain);
    man_hit    = man_en && (man_gain_c != target_q);
    req_fire   = req_valid && req_ready;

    state_d  = state_q;
    gain_d   = gain_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    if (man_hit) begin
      target_d = man_gain_c;
    end else if (req_fire) begin
      target_d = req_gain_c;
    end

    case (state_q)
      IDLE: begin
        if (man_hit) begin
          state_d = STEP;
        end else if (req_fire && (req_gain_c != gain_q)) begin
          state_d = STEP;
        end
      end
      STEP: begin
        // The step in flight always uses the target it started with.
        if (gain_q < target_q) begin
          gain_d = gain_q + 2'd1;
        end else if (gain_q > target_q) begin
          gain_d = gain_q - 2'd1;
        end
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (gain_q != target_d) begin
            state_d = STEP;
          end else begin
            state_d = DWELL;
            cnt_d   = DWELL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DWELL: begin
        if (man_hit) begin
          state_d = STEP;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded outputs, all combinational from registered state.
  always_comb begin
    settling  = (state_q == STEP) || (state_q == SETTLE);
    busy      = (state_q != IDLE);
    req_ready = (state_q == IDLE) && !man_en;
  end

  // One-stage sample pipe; samples taken while the analog path moves are
  // dropped by clearing their strobe.
  always_comb begin
    out_data_d  = adc_data;
    out_gain_d  = gain_q;
    out_valid_d = adc_valid && !settling;
  end

  assign gain_ctrl = gain_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_gain  = out_gain_q;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Testbench for agc_gain_sequencer. A plan-based reference model predicts,
// for every cycle, the gain on the PGA and whether the block is settling or
// busy; a separate monitor pops those predictions and the predicted samples
// and compares them with the DUT.
module tb_agc_gain_sequencer;

  localparam int S = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_gain = 2'd0;
  logic        man_en = 1'b0;
  logic [1:0]  man_gain = 2'd0;
  logic [11:0] adc_data = 12'd0;
  logic        adc_valid = 1'b0;
  logic        req_ready;
  logic [11:0] out_data;
  logic        out_valid;
  logic [1:0]  out_gain;
  logic [1:0]  gain_ctrl;
  logic        settling;
  logic        busy;

  // Second instance with a lower gain ceiling, used for the clamp check.
  logic        r2_valid = 1'b0;
  logic [1:0]  r2_gain = 2'd0;
  logic        r2_man_en = 1'b0;
  logic [1:0]  r2_man_gain = 2'd0;
  logic [11:0] r2_adc_data = 12'd0;
  logic        r2_adc_valid = 1'b0;
  logic        r2_ready;
  logic [11:0] r2_out_data;
  logic        r2_out_valid;
  logic [1:0]  r2_out_gain;
  logic [1:0]  r2_gain_ctrl;
  logic        r2_settling;
  logic        r2_busy;

  always #5 clk = ~clk;

  agc_gain_sequencer #(
    .SETTLE_CYCLES(S), .DWELL_CYCLES(D), .GAIN_INIT(2'd0), .MAX_GAIN(2'd3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_gain(req_gain), .req_ready(req_ready),
    .man_en(man_en), .man_gain(man_gain),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .out_data(out_data), .out_valid(out_valid), .out_gain(out_gain),
    .gain_ctrl(gain_ctrl), .settling(settling), .busy(busy)
  );

  agc_gain_sequencer #(
    .SETTLE_CYCLES(S), .DWELL_CYCLES(D), .GAIN_INIT(2'd0), .MAX_GAIN(2'd2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(r2_valid), .req_gain(r2_gain), .req_ready(r2_ready),
    .man_en(r2_man_en), .man_gain(r2_man_gain),
    .adc_data(r2_adc_data), .adc_valid(r2_adc_valid),
    .out_data(r2_out_data), .out_valid(r2_out_valid), .out_gain(r2_out_gain),
    .gain_ctrl(r2_gain_ctrl), .settling(r2_settling), .busy(r2_busy)
  );

  int checks = 0;
  int failures = 0;
  int ramp = 0;

  // One predicted cycle of the gain sequence. 'last' marks the final settle
  // cycle of a one-level move, which is where an override may re-plan.
  typedef struct {
    int gain;
    bit settling;
    bit busy;
    bit last;
  } ent_t;

  typedef struct {
    int gain;
    bit settling;
    bit busy;
    bit ready;
    bit ovalid;
  } stat_t;

  typedef struct {
    int data;
    int gain;
  } samp_t;

  ent_t  cur;
  ent_t  future[$];
  stat_t stat_q[$];
  samp_t samp_q[$];
  int    tgt;
  bit    prev_ov;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int clampg(input int g);
    return (g > 3) ? 3 : g;
  endfunction

  // Append the cycles needed to walk from gain g to gain t one level at a
  // time (one step cycle + S settle cycles per level), then the dwell.
  task automatic planMove(input int g0, input int t);
    int g;
    int dir;
    g   = g0;
    dir = (t > g) ? 1 : -1;
    while (g != t) begin
      future.push_back('{gain: g, settling: 1'b1, busy: 1'b1, last: 1'b0});
      g = g + dir;
      for (int i = 0; i < S; i++)
        future.push_back('{gain: g, settling: 1'b1, busy: 1'b1, last: (i == S - 1)});
    end
    for (int i = 0; i < D; i++)
      future.push_back('{gain: g, settling: 1'b0, busy: 1'b1, last: 1'b0});
  endtask

  task automatic modelReset();
    cur = '{gain: 0, settling: 1'b0, busy: 1'b0, last: 1'b0};
    future.delete();
    stat_q.delete();
    samp_q.delete();
    tgt = 0;
    prev_ov = 1'b0;
  endtask

  // Drive one cycle of inputs just after the rising edge, record what the DUT
  // must show during this cycle, and update the plan for the cycles ahead.
  task automatic applyStimulus(input bit rv, input int rg, input bit me, input int mg,
                               input bit av, input int ad);
    bit   ready;
    int   mgc;
    int   g;
    ent_t e;
    ent_t keep[$];
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = rv;
    req_gain  = rg[1:0];
    man_en    = me;
    man_gain  = mg[1:0];
    adc_valid = av;
    adc_data  = ad[11:0];

    ready = !cur.busy && !me;
    stat_q.push_back('{gain: cur.gain, settling: cur.settling, busy: cur.busy,
                       ready: ready, ovalid: prev_ov});

    mgc = clampg(mg);
    if (me && (mgc != tgt)) begin
      tgt = mgc;
      if (!cur.settling) begin
        future.delete();
        planMove(cur.gain, tgt);
      end else begin
        // The one-level move already under way finishes unchanged.
        g = cur.gain;
        if (!cur.last) begin
          while (future.size() > 0) begin
            e = future.pop_front();
            keep.push_back(e);
            g = e.gain;
            if (e.last) break;
          end
        end
        future = keep;
        planMove(g, tgt);
      end
    end else if (ready && rv) begin
      tgt = clampg(rg);
      if (tgt != cur.gain) planMove(cur.gain, tgt);
    end

    prev_ov = av && !cur.settling;
    if (prev_ov) samp_q.push_back('{data: ad & 12'hfff, gain: cur.gain});

    if (future.size() > 0) cur = future.pop_front();
    else cur = '{gain: cur.gain, settling: 1'b0, busy: 1'b0, last: 1'b0};
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, ramp);
    ramp = (ramp + 1) & 12'hfff;
  endtask

  task automatic runUntilIdle(input string name);
    int n;
    n = 0;
    while (cur.busy && n < 300) begin
      idleCycle();
      n++;
    end
    if (cur.busy) checkOutput({name, "_timeout"}, 1, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gain_ctrl"}, gain_ctrl, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_settling"}, settling, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_gain"}, out_gain, 0);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Monitor: compares the per-cycle predictions and every emitted sample.
  always @(negedge clk) begin
    stat_t s;
    samp_t p;
    if (!rst) begin
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        checkOutput("gain_ctrl", gain_ctrl, s.gain);
        checkOutput("settling", settling, s.settling);
        checkOutput("busy", busy, s.busy);
        checkOutput("req_ready", req_ready, s.ready);
        checkOutput("out_valid", out_valid, s.ovalid);
      end
      if (out_valid) begin
        if (samp_q.size() > 0) begin
          p = samp_q.pop_front();
          checkOutput("out_data", out_data, p.data);
          checkOutput("out_gain", out_gain, p.gain);
        end else begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_sample at %0t: out_valid=1 with no sample expected", $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit man_on;
    int man_g;
    modelReset();
    $display("[TB] reset check");
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    idleCycle();
    idleCycle();

    $display("[TB] full-range step with blanking, clamp instance in parallel");
    r2_valid = 1'b1;
    r2_gain  = 2'd3;
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b1, ramp);
    ramp++;
    r2_valid = 1'b0;
    repeat (30) idleCycle();
    checkOutput("clamp_gain_ctrl", r2_gain_ctrl, 2);
    checkOutput("clamp_busy", r2_busy, 0);

    $display("[TB] no-op request");
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b1, ramp);
    repeat (4) idleCycle();

    $display("[TB] manual override in dwell");
    applyStimulus(1'b1, 1, 1'b0, 0, 1'b1, ramp);
    runUntilIdle("down_to_1");
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b1, ramp);
    n = 0;
    while (!(cur.busy && !cur.settling) && n < 100) begin
      idleCycle();
      n++;
    end
    idleCycle();
    idleCycle();
    for (int i = 0; i < 45; i++) applyStimulus(1'b1, 3, 1'b1, 0, 1'b1, i);
    runUntilIdle("override");

    $display("[TB] retarget during settle");
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b1, ramp);
    n = 0;
    while (!(cur.settling && cur.gain == 1) && n < 100) begin
      idleCycle();
      n++;
    end
    idleCycle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b1, 2, 1'b1, i);
    runUntilIdle("retarget");

    $display("[TB] reset in settle at gain 2");
    applyStimulus(1'b1, 0, 1'b0, 0, 1'b1, ramp);
    runUntilIdle("down_to_0");
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b1, ramp);
    n = 0;
    while (!(cur.settling && cur.gain == 2) && n < 100) begin
      idleCycle();
      n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkResetValues("mid_settle_reset");
    modelReset();
    repeat (2) @(posedge clk);
    idleCycle();

    $display("[TB] randomized traffic");
    man_on = 1'b0;
    man_g  = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        man_on = !man_on;
        man_g  = $urandom_range(0, 3);
      end
      if (man_on && $urandom_range(0, 99) < 5) man_g = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 99) < 25, $urandom_range(0, 3), man_on, man_g,
                    $urandom_range(0, 1), $urandom_range(0, 4095));
    end

    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("samples_pending", samp_q.size(), 0);
    checkOutput("status_pending", stat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
